// File: rtl/epcs_rope_arbiter_if.sv
// Requester fetch ports, EPCS flash pins and BUSY of the rope-image arbiter.
// The arbiter connects through the slave modport; the requester/flash side uses master.
interface epcs_rope_arbiter_if;
    logic        AGC_REQ;
    logic [15:0] AGC_ADDR;
    logic        AGC_ACK;
    logic [15:0] AGC_DATA;
    logic        DBG_REQ;
    logic [15:0] DBG_ADDR;
    logic        DBG_ACK;
    logic [15:0] DBG_DATA;
    logic        EPCS_CSN;
    logic        EPCS_DCLK;
    logic        EPCS_ASDI;
    logic        EPCS_DATA;
    logic        BUSY;

    modport slave (
        input  AGC_REQ, AGC_ADDR, DBG_REQ, DBG_ADDR, EPCS_DATA,
        output AGC_ACK, AGC_DATA, DBG_ACK, DBG_DATA,
        output EPCS_CSN, EPCS_DCLK, EPCS_ASDI, BUSY
    );

    modport master (
        output AGC_REQ, AGC_ADDR, DBG_REQ, DBG_ADDR, EPCS_DATA,
        input  AGC_ACK, AGC_DATA, DBG_ACK, DBG_DATA,
        input  EPCS_CSN, EPCS_DCLK, EPCS_ASDI, BUSY
    );
endinterface

// File: rtl/epcs_rope_arbiter.sv
// Shares the EPCS rope-image flash between the AGC fetch port (priority) and a debug port,
// one SPI READ of one 16-bit word per grant. Optional one-word cache: EPCS_LASTWORD_CACHE_EN.
module epcs_rope_arbiter #(
    parameter int unsigned CLK_DIV   = 2,
    parameter logic [23:0] BASE_ADDR = 24'h080000
) (
    input logic                SIM_CLK,
    input logic                SIM_RST,
    epcs_rope_arbiter_if.slave bus
);
    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       BIT_RD   = 6'd32;
    localparam logic [5:0]       BIT_LAST = 6'd47;
    localparam logic [7:0]       CMD_READ = 8'h03;

    typedef enum logic [2:0] {S_IDLE, S_SEL, S_SHIFT, S_DONE, S_GAP} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [5:0]       r_bit;
    logic [47:0]      r_frame;
    logic [15:0]      r_word;
    logic             r_gnt_dbg;
    logic             r_csn;
    logic             r_dclk;
    logic             r_busy;
    logic             r_agc_ack;
    logic             r_dbg_ack;
    logic [15:0]      r_agc_data;
    logic [15:0]      r_dbg_data;

    logic             w_req_any;
    logic [15:0]      w_req_addr;
    logic [23:0]      w_byte_addr;
    logic             w_div_end;
    logic             w_last_fall;

    assign w_req_any   = bus.AGC_REQ | bus.DBG_REQ;
    assign w_req_addr  = bus.AGC_REQ ? bus.AGC_ADDR : bus.DBG_ADDR;
    assign w_byte_addr = BASE_ADDR + {7'd0, w_req_addr, 1'b0};
    assign w_div_end   = (r_div == DIV_LAST);
    // Falling DCLK closing period 47: the word register is complete at this point.
    assign w_last_fall = (r_state == S_SHIFT) && w_div_end && r_dclk && (r_bit == BIT_LAST);

`ifdef EPCS_LASTWORD_CACHE_EN
    logic        r_c_valid;
    logic        r_hit;
    logic [23:0] r_c_addr;
    logic [23:0] r_c_tag;
    logic [15:0] r_c_word;
    logic        w_hit;

    assign w_hit = r_c_valid && (r_c_tag == w_byte_addr);

    // NOTE: tag, word and pending address are pure storage qualified by r_c_valid, so only the
    // valid bit is reset; leaving them out of the async-reset block keeps them plain enable flops.
    always_ff @(posedge SIM_CLK) begin
        if (r_state == S_IDLE && w_req_any) r_c_addr <= w_byte_addr;
        if (w_last_fall) begin
            r_c_tag  <= r_c_addr;
            r_c_word <= r_word;
        end
    end
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples the
    // pre-edge values of the others, which is what makes the shift/sample ordering correct.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_frame    <= '0;
            r_word     <= '0;
            r_gnt_dbg  <= 1'b0;
            r_csn      <= 1'b1;
            r_dclk     <= 1'b0;
            r_busy     <= 1'b0;
            r_agc_ack  <= 1'b0;
            r_dbg_ack  <= 1'b0;
            r_agc_data <= '0;
            r_dbg_data <= '0;
`ifdef EPCS_LASTWORD_CACHE_EN
            r_c_valid  <= 1'b0;
            r_hit      <= 1'b0;
`endif
        end else begin
            r_agc_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req_any) begin
                        r_gnt_dbg <= ~bus.AGC_REQ;
                        r_frame   <= {CMD_READ, w_byte_addr, 16'h0000};
                        r_div     <= '0;
                        r_bit     <= '0;
                        r_busy    <= 1'b1;
`ifdef EPCS_LASTWORD_CACHE_EN
                        r_hit     <= w_hit;
                        if (w_hit) begin
                            r_state <= S_DONE;
                            if (bus.AGC_REQ) begin
                                r_agc_ack  <= 1'b1;
                                r_agc_data <= r_c_word;
                            end else begin
                                r_dbg_ack  <= 1'b1;
                                r_dbg_data <= r_c_word;
                            end
                        end else begin
                            r_state <= S_SEL;
                            r_csn   <= 1'b0;
                        end
`else
                        r_state   <= S_SEL;
                        r_csn     <= 1'b0;
`endif
                    end
                end
                S_SEL: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        r_div  <= '0;
                        r_dclk <= ~r_dclk;
                        if (!r_dclk) begin
                            if (r_bit >= BIT_RD) r_word <= {r_word[14:0], bus.EPCS_DATA};
                        end else if (w_last_fall) begin
                            r_state <= S_DONE;
                            r_csn   <= 1'b1;
`ifdef EPCS_LASTWORD_CACHE_EN
                            r_c_valid <= 1'b1;
`endif
                            if (r_gnt_dbg) begin
                                r_dbg_ack  <= 1'b1;
                                r_dbg_data <= r_word;
                            end else begin
                                r_agc_ack  <= 1'b1;
                                r_agc_data <= r_word;
                            end
                        end else begin
                            // ASDI advances together with the falling DCLK, so it is stable across the next rise.
                            r_bit   <= r_bit + 1'b1;
                            r_frame <= {r_frame[46:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
`ifdef EPCS_LASTWORD_CACHE_EN
                    if (r_hit) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= S_GAP;
                        r_div   <= '0;
                    end
`else
                    r_state <= S_GAP;
                    r_div   <= '0;
`endif
                end
                S_GAP: begin
                    r_div <= r_div + 1'b1;
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.EPCS_CSN  = r_csn;
    assign bus.EPCS_DCLK = r_dclk;
    assign bus.EPCS_ASDI = r_frame[47];
    assign bus.AGC_ACK   = r_agc_ack;
    assign bus.AGC_DATA  = r_agc_data;
    assign bus.DBG_ACK   = r_dbg_ack;
    assign bus.DBG_DATA  = r_dbg_data;
    assign bus.BUSY      = r_busy;
endmodule

// File: tb/tb_epcs_rope_arbiter.sv
// Directed bench for epcs_rope_arbiter: SPI flash model, ack scoreboard, reset/wrap/cache checks.
module tb_epcs_rope_arbiter;
    localparam int          N      = 2;
    localparam int          ACK_AT = 97 * N + 1;
    localparam int          PERIOD = 98 * N + 2;
    localparam logic [23:0] BASE0  = 24'h080000;
    localparam logic [23:0] BASE1  = 24'hFFFFFE;
    localparam logic [7:0]  RD     = 8'h03;

    typedef struct {
        logic        is_dbg;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic SIM_CLK = 1'b0;
    logic SIM_RST = 1'b0;

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;
    int   agc_acks  = 0;
    int   dbg_acks  = 0;
    int   csn_falls = 0;
    exp_t sb[$];
    logic [31:0] frames[$];

    int          fcnt;
    logic [31:0] frx;
    int          fl_d;
    logic [7:0]  fl_b;
    int          cnt1;
    logic [31:0] rx1;

    epcs_rope_arbiter_if bus0 ();
    epcs_rope_arbiter_if bus1 ();

    epcs_rope_arbiter #(.CLK_DIV(N), .BASE_ADDR(BASE0)) u_dut0 (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .bus     (bus0)
    );

    epcs_rope_arbiter #(.CLK_DIV(N), .BASE_ADDR(BASE1)) u_dut1 (
        .SIM_CLK (SIM_CLK),
        .SIM_RST (SIM_RST),
        .bus     (bus1)
    );

    always #5 SIM_CLK = ~SIM_CLK;

    always @(posedge SIM_CLK) begin
        cyc <= cyc + 1;
        if (bus0.AGC_ACK === 1'b1) agc_acks <= agc_acks + 1;
        if (bus0.DBG_ACK === 1'b1) dbg_acks <= dbg_acks + 1;
    end

    always @(negedge bus0.EPCS_CSN) csn_falls <= csn_falls + 1;

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h080000: return 8'hA5;
            24'h080001: return 8'h3C;
            default:    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h96;
        endcase
    endfunction

    function automatic logic [15:0] exp_word(input logic [23:0] base, input logic [15:0] addr);
        logic [23:0] b;
        b = base + {7'd0, addr, 1'b0};
        return {flash_byte(b), flash_byte(b + 24'd1)};
    endfunction

    // Flash model for dut0: mode 0, command/address captured on rising DCLK, data driven on falling.
    always @(posedge bus0.EPCS_DCLK or posedge bus0.EPCS_CSN) begin
        if (bus0.EPCS_CSN) begin
            fcnt <= 0;
        end else begin
            if (fcnt < 32) frx <= {frx[30:0], bus0.EPCS_ASDI};
            if (fcnt == 31) frames.push_back({frx[30:0], bus0.EPCS_ASDI});
            fcnt <= fcnt + 1;
        end
    end

    always @(negedge bus0.EPCS_DCLK) begin
        if (bus0.EPCS_CSN === 1'b0 && fcnt >= 32 && fcnt < 48) begin
            fl_d = fcnt - 32;
            fl_b = flash_byte(frx[23:0] + 24'(fl_d / 8));
            bus0.EPCS_DATA <= fl_b[7 - (fl_d % 8)];
        end
    end

    // dut1 only needs its command/address captured; its flash reads all ones.
    always @(posedge bus1.EPCS_DCLK or posedge bus1.EPCS_CSN) begin
        if (bus1.EPCS_CSN) begin
            cnt1 <= 0;
        end else begin
            if (cnt1 < 32) rx1 <= {rx1[30:0], bus1.EPCS_ASDI};
            cnt1 <= cnt1 + 1;
        end
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic is_dbg, input logic [15:0] data, input int at);
        exp_t e;
        e.is_dbg = is_dbg;
        e.data   = data;
        e.cyc    = at;
        sb.push_back(e);
    endtask

    task automatic expect_ack(input string tag, input int budget);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge SIM_CLK);
            seen = (bus0.AGC_ACK === 1'b1) || (bus0.DBG_ACK === 1'b1);
        end
        check({tag, "_seen"}, seen, 1'b1);
        check({tag, "_sb"}, sb.size() > 0, 1'b1);
        if (seen && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_port"}, {bus0.AGC_ACK, bus0.DBG_ACK}, e.is_dbg ? 2'b01 : 2'b10);
            check({tag, "_data"}, e.is_dbg ? bus0.DBG_DATA : bus0.AGC_DATA, e.data);
            check({tag, "_cyc"}, cyc, e.cyc);
        end
    endtask

    task automatic check_frame(input string tag, input logic [31:0] exp);
        check({tag, "_present"}, frames.size() > 0, 1'b1);
        if (frames.size() > 0) check(tag, frames.pop_front(), exp);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 500 && bus0.BUSY !== 1'b0; i++) @(negedge SIM_CLK);
        check(tag, bus0.BUSY, 1'b0);
    endtask

    task automatic fetch_agc(input string tag, input logic [15:0] addr, input int lat);
        @(negedge SIM_CLK);
        bus0.AGC_ADDR = addr;
        bus0.AGC_REQ  = 1'b1;
        push_exp(1'b0, exp_word(BASE0, addr), cyc + lat);
        expect_ack(tag, 400);
        bus0.AGC_REQ = 1'b0;
        wait_idle({tag, "_idle"});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t0;
        int          a_cyc;
        int          n_agc;
        int          n_dbg;
        int          falls0;
        logic [15:0] first_word;

        bus0.AGC_REQ  = 1'b0;
        bus0.AGC_ADDR = '0;
        bus0.DBG_REQ  = 1'b0;
        bus0.DBG_ADDR = '0;
        bus1.AGC_REQ  = 1'b0;
        bus1.AGC_ADDR = '0;
        bus1.DBG_REQ  = 1'b0;
        bus1.DBG_ADDR = '0;
        bus1.EPCS_DATA = 1'b1;

        // Reset values
        repeat (2) @(negedge SIM_CLK);
        check("rst_csn", bus0.EPCS_CSN, 1'b1);
        check("rst_dclk", bus0.EPCS_DCLK, 1'b0);
        check("rst_asdi", bus0.EPCS_ASDI, 1'b0);
        check("rst_acks", {bus0.AGC_ACK, bus0.DBG_ACK}, 2'b00);
        check("rst_agc_data", bus0.AGC_DATA, 16'h0000);
        check("rst_dbg_data", bus0.DBG_DATA, 16'h0000);
        check("rst_busy", bus0.BUSY, 1'b0);
        SIM_RST = 1'b1;
        repeat (2) @(negedge SIM_CLK);

        // Single AGC fetch of word 0: ack timing, data, frame, deselect gap, BUSY drop
        @(negedge SIM_CLK);
        bus0.AGC_ADDR = 16'h0000;
        bus0.AGC_REQ  = 1'b1;
        t0 = cyc;
        push_exp(1'b0, exp_word(BASE0, 16'h0000), t0 + ACK_AT);
        expect_ack("t1", 400);
        bus0.AGC_REQ = 1'b0;
        check("t1_word", bus0.AGC_DATA, 16'hA53C);
        check("t1_ack_at_195", cyc - t0, 195);
        check_frame("t1_frame", {RD, 24'h080000});
        @(negedge SIM_CLK);
        @(negedge SIM_CLK);
        check("t1_gap_csn", bus0.EPCS_CSN, 1'b1);
        check("t1_gap_busy", bus0.BUSY, 1'b1);
        @(negedge SIM_CLK);
        check("t1_busy_drop", bus0.BUSY, 1'b0);
        check("t1_busy_cyc", cyc - t0, PERIOD);

        // Simultaneous requests: AGC first, debug one period later
        @(negedge SIM_CLK);
        bus0.AGC_ADDR = 16'h0010;
        bus0.DBG_ADDR = 16'h0020;
        bus0.AGC_REQ  = 1'b1;
        bus0.DBG_REQ  = 1'b1;
        t0 = cyc;
        push_exp(1'b0, exp_word(BASE0, 16'h0010), t0 + ACK_AT);
        push_exp(1'b1, exp_word(BASE0, 16'h0020), t0 + PERIOD + ACK_AT);
        expect_ack("t3_agc", 400);
        bus0.AGC_REQ = 1'b0;
        a_cyc = cyc;
        expect_ack("t3_dbg", 400);
        bus0.DBG_REQ = 1'b0;
        check("t3_spacing", cyc - a_cyc, PERIOD);
        check_frame("t3_frame_agc", {RD, 24'h080020});
        check_frame("t3_frame_dbg", {RD, 24'h080040});
        wait_idle("t3_idle");

        // Asynchronous reset at the 20th DCLK of a transfer
        @(negedge SIM_CLK);
        bus0.AGC_ADDR = 16'h0005;
        bus0.AGC_REQ  = 1'b1;
        n_agc = agc_acks;
        n_dbg = dbg_acks;
        for (int i = 0; i < 600 && fcnt != 20; i++) @(negedge SIM_CLK);
        check("t4_dclk20", fcnt, 20);
        check("t4_dclk_high", bus0.EPCS_DCLK, 1'b1);
        SIM_RST = 1'b0;
        #1;
        check("t4_csn", bus0.EPCS_CSN, 1'b1);
        check("t4_dclk", bus0.EPCS_DCLK, 1'b0);
        check("t4_agc_data", bus0.AGC_DATA, 16'h0000);
        check("t4_dbg_data", bus0.DBG_DATA, 16'h0000);
        check("t4_busy", bus0.BUSY, 1'b0);
        bus0.AGC_REQ = 1'b0;
        repeat (4) @(negedge SIM_CLK);
        SIM_RST = 1'b1;
        repeat (PERIOD) @(negedge SIM_CLK);
        check("t4_no_ack", {agc_acks - n_agc, dbg_acks - n_dbg}, 64'd0);
        fetch_agc("t4_after", 16'h0005, ACK_AT);
        check_frame("t4_frame", {RD, 24'h08000A});

        // Debug request withdrawn one cycle after grant, address changed after grant
        @(negedge SIM_CLK);
        bus0.DBG_ADDR = 16'h0033;
        bus0.DBG_REQ  = 1'b1;
        t0 = cyc;
        n_dbg = dbg_acks;
        push_exp(1'b1, exp_word(BASE0, 16'h0033), t0 + ACK_AT);
        @(negedge SIM_CLK);
        bus0.DBG_REQ  = 1'b0;
        bus0.DBG_ADDR = 16'hFFFF;
        expect_ack("t5", 400);
        repeat (PERIOD) @(negedge SIM_CLK);
        check("t5_once", dbg_acks - n_dbg, 1);
        check("t5_idle", bus0.BUSY, 1'b0);
        check_frame("t5_frame", {RD, 24'h080066});

        // 24-bit address wrap on the second instance
        @(negedge SIM_CLK);
        bus1.AGC_ADDR = 16'h0001;
        bus1.AGC_REQ  = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 400 && bus1.AGC_ACK !== 1'b1; i++) @(negedge SIM_CLK);
        bus1.AGC_REQ = 1'b0;
        check("t6_ack", bus1.AGC_ACK, 1'b1);
        check("t6_cyc", cyc - t0, ACK_AT);
        check("t6_data", bus1.AGC_DATA, 16'hFFFF);
        check("t6_frame", rx1, {RD, 24'h000000});
        repeat (PERIOD) @(negedge SIM_CLK);

        // Repeated fetch of the same word, then a neighbouring word
        fetch_agc("t7_first", 16'h0100, ACK_AT);
        check_frame("t7_frame_first", {RD, 24'h080200});
        first_word = bus0.AGC_DATA;
        falls0 = csn_falls;
`ifdef EPCS_LASTWORD_CACHE_EN
        fetch_agc("t7_repeat", 16'h0100, 1);
        check("t7_repeat_csn", csn_falls - falls0, 0);
`else
        fetch_agc("t7_repeat", 16'h0100, ACK_AT);
        check("t7_repeat_csn", csn_falls - falls0, 1);
        check_frame("t7_frame_repeat", {RD, 24'h080200});
`endif
        check("t7_repeat_same", bus0.AGC_DATA, first_word);
        falls0 = csn_falls;
        fetch_agc("t7_next", 16'h0101, ACK_AT);
        check("t7_next_csn", csn_falls - falls0, 1);
        check_frame("t7_frame_next", {RD, 24'h080202});
        check("sb_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
